run_ctrl: RTL
=============

RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning instruction-memory word-address width (depth 2^ADDR_W).
REQ-002 SHALL have parameter HALT_PC, default 32'hF000_0100, meaning the PC value that ends a run.
REQ-003 SHALL have parameter MAX_CYCLES, default 1000, meaning the RUN-cycle budget before timeout.
REQ-004 SHALL have port clk  in  1  meaning the single system clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst  in  1  meaning asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  in  1  meaning a program word is offered.
REQ-007 SHALL have port in_data  in  32  meaning the program word.
REQ-008 SHALL have port in_last  in  1  meaning the offered word is the final word of the program.
REQ-009 SHALL have port in_ready  out  1  meaning the block accepts the offered word this cycle.
REQ-010 SHALL have port im_we  out  1  meaning write strobe to instruction memory.
REQ-011 SHALL have port im_addr  out  ADDR_W  meaning instruction-memory word address.
REQ-012 SHALL have port im_wdata  out  32  meaning instruction-memory write data.
REQ-013 SHALL have port cpu_rstn  out  1  meaning active-low reset driven to the CPU.
REQ-014 SHALL have port pc  in  32  meaning the current PC of the CPU.
REQ-015 SHALL have port done  out  1  meaning the run has finished (sticky).
REQ-016 SHALL have port reason  out  2  meaning why the run finished: 0 none, 1 halt, 2 timeout, 3 overflow.
REQ-017 SHALL have port cycle_cnt  out  32  meaning the number of RUN cycles elapsed.
REQ-018 SHALL have port word_cnt  out  ADDR_W+1  meaning the number of program words loaded.

Function
REQ-019 SHALL implement the FSM states LOAD, CPURST, RUN and DONE; the state after reset is LOAD.
REQ-020 In LOAD, SHALL drive in_ready=1 and hold cpu_rstn=0.
REQ-021 On each LOAD handshake (in_valid & in_ready), SHALL drive im_we=1, im_addr=word_cnt[ADDR_W-1:0] and im_wdata=in_data combinationally in the same cycle, and increment word_cnt.
REQ-022 On a handshake with in_last=1, SHALL go to CPURST.
REQ-023 On a handshake with word_cnt=2^ADDR_W-1 and in_last=0, SHALL write the word, set reason=3 and go to DONE (overflow, no wrap-around).
REQ-024 In CPURST, SHALL hold cpu_rstn=0 for exactly 2 cycles, then go to RUN; in_ready=0 and im_we=0.
REQ-025 In RUN, SHALL drive cpu_rstn=1 and increment cycle_cnt every cycle, starting from 0.
REQ-026 In RUN, when pc==HALT_PC, SHALL go to DONE with reason=1.
REQ-027 In RUN, when cycle_cnt==MAX_CYCLES-1, SHALL go to DONE with reason=2.
REQ-028 When halt and timeout occur in the same cycle, halt SHALL take priority (reason=1).
REQ-029 In DONE, SHALL drive done=1, freeze cycle_cnt, reason and word_cnt, keep cpu_rstn=1 (register file remains readable), and drive in_ready=0.
REQ-030 SHALL leave DONE only via rst.
REQ-031 In every cycle without a LOAD handshake, SHALL hold im_we=0; im_addr and im_wdata are don't-care.

Reset
REQ-032 rst SHALL asynchronously force state=LOAD, cpu_rstn=0, done=0, reason=0, cycle_cnt=0 and word_cnt=0.
REQ-033 rst asserted mid-LOAD or mid-RUN SHALL abort the operation; no partial state survives, and memory contents are not cleared.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding and the reason codes (RSN_NONE, RSN_HALT, RSN_TIMEOUT, RSN_OVF).
REQ-035 The block SHALL be a single module with no sub-modules; instruction memory remains external.

Verification
REQ-036 Test 1: load 37 words with in_last on word 37 -> 37 im_we pulses at addresses 0..36, word_cnt=37, cpu_rstn low for 2 cycles after the last word, then high.
REQ-037 Test 2: in RUN, drive pc=32'hF000_0100 at cycle 12 -> done=1 and reason=1 on the next edge, cycle_cnt frozen at 12.
REQ-038 Test 3: pc never reaches HALT_PC -> done=1 and reason=2 after exactly 1000 RUN cycles, cycle_cnt=999.
REQ-039 Test 4: with ADDR_W=2, feed 4 words with no in_last -> reason=3, done=1, cpu_rstn never goes high.
REQ-040 Test 5: pc==HALT_PC exactly at cycle_cnt=999 -> reason=1.
REQ-041 Test 6: pulse rst mid-RUN, then reload 3 words -> all counters restart at 0, done=0, and the FSM returns to LOAD within the same cycle as rst.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// rtl/run_ctrl_pkg.sv - shared FSM state encoding and finish-reason codes for run_ctrl
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_CPURST = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [1:0] RSN_NONE    = 2'd0;
  localparam logic [1:0] RSN_HALT    = 2'd1;
  localparam logic [1:0] RSN_TIMEOUT = 2'd2;
  localparam logic [1:0] RSN_OVF     = 2'd3;

endpackage

// File: rtl/run_ctrl.sv
// rtl/run_ctrl.sv - program loader and CPU run supervisor (load, reset pulse, run, finish)
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int          ADDR_W     = 10,
  parameter logic [31:0] HALT_PC    = 32'hF000_0100,
  parameter int          MAX_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rstn,
  input  logic [31:0]       pc,
  output logic              done,
  output logic [1:0]        reason,
  output logic [31:0]       cycle_cnt,
  output logic [ADDR_W:0]   word_cnt
);

  // Highest word address: a non-final word written here would need to wrap.
  localparam logic [ADDR_W:0] WORD_LAST = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] WORD_ONE  = (ADDR_W+1)'(1);
  localparam logic [31:0]     CYC_LAST  = 32'(MAX_CYCLES - 1);

  state_t     state;
  state_t     state_nx;
  logic [1:0] reason_nx;
  logic       rst_cnt;
  logic       hs;

  assign hs       = (state == ST_LOAD) && in_valid;
  assign in_ready = (state == ST_LOAD);
  assign im_we    = hs;
  assign im_addr  = word_cnt[ADDR_W-1:0];
  assign im_wdata = in_data;
  assign done     = (state == ST_DONE);
  // An overflow aborts before the CPU was ever released, so it stays in reset.
  assign cpu_rstn = (state == ST_RUN) || ((state == ST_DONE) && (reason != RSN_OVF));

  // State and finish-reason registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_LOAD;
      reason <= RSN_NONE;
    end else begin
      state  <= state_nx;
      reason <= reason_nx;
    end
  end

  // Next-state decode; halt is tested before timeout so it wins a tie.
  always_comb begin
    state_nx  = state;
    reason_nx = reason;
    case (state)
      ST_LOAD: begin
        if (hs) begin
          if (in_last) begin
            state_nx = ST_CPURST;
          end else if (word_cnt == WORD_LAST) begin
            state_nx  = ST_DONE;
            reason_nx = RSN_OVF;
          end
        end
      end
      ST_CPURST: begin
        if (rst_cnt) state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (pc == HALT_PC) begin
          state_nx  = ST_DONE;
          reason_nx = RSN_HALT;
        end else if (cycle_cnt == CYC_LAST) begin
          state_nx  = ST_DONE;
          reason_nx = RSN_TIMEOUT;
        end
      end
      default: begin
        state_nx = ST_DONE;
      end
    endcase
  end

  // Word, reset-pulse and run-cycle counters; cycle_cnt stops on the finishing cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt  <= '0;
      rst_cnt   <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      if (hs) word_cnt <= word_cnt + WORD_ONE;
      rst_cnt <= (state == ST_CPURST) && !rst_cnt;
      if ((state == ST_RUN) && (state_nx == ST_RUN)) cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

endmodule
